lfsr_scrambler: RTL and testbench
=================================

# lfsr_scrambler

Parametrised pseudo-random word generator that replaces the fixed lookup-table randomiser in the game datapath. It uses a maximal-length Fibonacci LFSR whose width is chosen by parameter. A free-running entropy counter is folded into the LFSR state on each press of the scramble button. Random words are produced through a Req/Valid handshake that serially clocks the LFSR. It sits between the debounced button inputs and the shuffle/game-state logic.

## Interface
- WIDTH, 32: LFSR width. Legal values are 8, 16, 24 and 32; any other value is illegal.
- OUT_W, 32: width of RandBits. Range 1..32.
- STEPS, 32: number of LFSR shifts per output word. Range 1..63.
- SEED, 1: LFSR reset value. Must be nonzero and must fit in WIDTH bits.
- clk  in  1  system clock. The block uses this one clock and no other.
- rst  in  1  synchronous, active-high reset.
- ScrambleButton  in  1  debounced button level, synchronous to clk.
- Req  in  1  request one random word. Sampled only in IDLE.
- Busy  out  1  high while the block is generating a word.
- Valid  out  1  one-cycle pulse: RandBits has just been updated.
- RandBits  out  OUT_W  last generated word. Held until the next word completes.

## Operation
- Taps. Feedback is the XOR of the listed 1-based state bits, shifted into bit 0:
  - WIDTH=8: bits 8,6,5,4.
  - WIDTH=16: bits 16,15,13,4.
  - WIDTH=24: bits 24,23,22,17.
  - WIDTH=32: bits 32,22,2,1.
- Step: lfsr <= {lfsr[WIDTH-2:0], fb}. The output bit for that step is lfsr[WIDTH-1] before the shift. It enters accumulator bit 0 and earlier bits move up: acc <= {acc, bit}.
- Entropy counter:
  - WIDTH bits, increments every cycle and wraps naturally.
  - Is not affected by Req or ScrambleButton.
- Scramble:
  - btn_q registers ScrambleButton.
  - A rising edge (ScrambleButton=1, btn_q=0) loads lfsr <= lfsr ^ counter, using the counter value in that cycle.
  - If the result would be zero, lfsr <= SEED instead, so the all-zero lock state can never be loaded.
- FSM, two states:
  - IDLE: Busy=0. If Req=1, go to GEN, clear the accumulator and clear the step count.
  - GEN: Busy=1. Each cycle performs one step and increments the count.
  - On the step that brings the count to STEPS: RandBits <= acc[OUT_W-1:0] including the final bit, Valid <= 1, and the FSM returns to IDLE.
- Width rule: if STEPS < OUT_W, the upper OUT_W-STEPS bits of RandBits are 0. If STEPS > OUT_W, only the last OUT_W bits collected are kept.
- Req while Busy=1 is ignored and is not queued.
- Scramble edge in the same cycle as a GEN step: the scramble load wins. No step occurs that cycle and the count does not advance, so the word completes one cycle later.
- Scramble edge in the same cycle as Req in IDLE: both take effect. The LFSR is seeded and the FSM enters GEN.

## Timing
- Reset values:
  - lfsr=SEED, counter=0, btn_q=0.
  - State IDLE, step count 0, accumulator 0.
  - Busy=0, Valid=0, RandBits=0.
- Reset during GEN abandons the word. Valid does not pulse, and RandBits is 0 after reset.
- Latency, with Req sampled at edge k and no scramble interference:
  - Busy=1 after edge k.
  - Steps occur at edges k+1..k+STEPS.
  - Valid=1 and RandBits are updated after edge k+STEPS. Valid deasserts after edge k+STEPS+1.
- Throughput: the next Req can be accepted at edge k+STEPS+1, giving one word per STEPS+1 cycles.
- Valid is exactly one cycle wide and never back-to-back.
- A scramble load is visible in lfsr one cycle after the edge is sampled.

## Configuration
- RANDOM_FREERUN_EN defined:
  - The LFSR also steps once every IDLE cycle in which no scramble load occurs.
  - The output therefore depends on how long the block idles before Req.
  - The accumulator is not touched in IDLE.
- RANDOM_FREERUN_EN undefined:
  - The LFSR is frozen in IDLE.
  - The word sequence is a deterministic function of SEED and scramble events only.
- Reset values and handshake timing are identical in both builds.

## Test plan
All scenarios use WIDTH=8, OUT_W=8, STEPS=8, SEED=1 with RANDOM_FREERUN_EN undefined, unless noted.
- Reset, then one Req pulse -> Busy high for 8 cycles, Valid pulses once after 8 cycles, RandBits=0x01, internal lfsr=0x1C.
- A second Req after that Valid -> RandBits=0x1C.
- Hold Req high continuously -> Valid pulses every 9 cycles, and the words follow the sequence 0x01, 0x1C, ...
- Scramble rising edge when counter=5 with lfsr=0x01, then Req -> lfsr=0x04 the next cycle, RandBits=0x04.
- Scramble rising edge when counter=1 with lfsr=0x01 (XOR would be 0) -> lfsr=0x01, never 0x00.
- Assert rst at step 4 of GEN -> no Valid pulse, Busy=0, RandBits=0. A new Req then yields 0x01.
- With RANDOM_FREERUN_EN defined, idle 3 cycles after reset, then Req -> RandBits=0x08. This differs from the undefined build, which gives 0x01.

Source files
------------

// File: rtl/lfsr_scrambler.sv
// Parametrised Fibonacci LFSR word generator with button-driven entropy folding and Req/Valid handshake.
// Optional build macro: RANDOM_FREERUN_EN (LFSR also steps during IDLE).
module lfsr_scrambler #(
  parameter int          WIDTH = 32,
  parameter int          OUT_W = 32,
  parameter int          STEPS = 32,
  parameter logic [31:0] SEED  = 32'd1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ScrambleButton,
  input  logic             Req,
  output logic             Busy,
  output logic             Valid,
  output logic [OUT_W-1:0] RandBits
);

  function automatic logic [31:0] tap_mask(input int w);
    case (w)
      8:       return 32'h0000_00B8;
      16:      return 32'h0000_D008;
      24:      return 32'h00E1_0000;
      default: return 32'h8020_0003;
    endcase
  endfunction

  localparam logic [WIDTH-1:0] TAPS   = WIDTH'(tap_mask(WIDTH));
  localparam logic [WIDTH-1:0] SEED_W = WIDTH'(SEED);
  localparam logic [5:0]       LAST   = 6'(STEPS - 1);

  typedef enum logic {
    IDLE,
    GEN
  } state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   lfsr, lfsr_next;
  logic [WIDTH-1:0]   counter;
  logic               btn_q;
  logic [OUT_W-1:0]   acc, acc_next, acc_shift;
  logic [5:0]         count, count_next;
  logic [OUT_W-1:0]   rand_q, rand_next;
  logic               valid_q, valid_next;

  logic               fb;
  logic               step_bit;
  logic [WIDTH-1:0]   step_val;
  logic [WIDTH-1:0]   folded;
  logic [WIDTH-1:0]   scramble_val;
  logic               scramble;

  always_comb begin
    fb           = ^(lfsr & TAPS);
    step_bit     = lfsr[WIDTH-1];
    step_val     = {lfsr[WIDTH-2:0], fb};
    scramble     = ScrambleButton & ~btn_q;
    folded       = lfsr ^ counter;
    scramble_val = (folded == '0) ? SEED_W : folded;
  end

  // A one-bit accumulator simply holds the latest output bit.
  generate
    if (OUT_W == 1) begin : g_acc1
      assign acc_shift = step_bit;
    end else begin : g_accn
      assign acc_shift = {acc[OUT_W-2:0], step_bit};
    end
  endgenerate

  always_comb begin
    state_next = state;
    lfsr_next  = lfsr;
    acc_next   = acc;
    count_next = count;
    rand_next  = rand_q;
    valid_next = 1'b0;
    Busy       = 1'b0;

    if (scramble) begin
      lfsr_next = scramble_val;
    end

    case (state)
      IDLE: begin
        Busy = 1'b0;
        if (Req) begin
          state_next = GEN;
          acc_next   = '0;
          count_next = '0;
        end
`ifdef RANDOM_FREERUN_EN
        if (!scramble) begin
          lfsr_next = step_val;
        end
`else
`endif
      end
      GEN: begin
        Busy = 1'b1;
        // A scramble load pre-empts the step, stretching the word by one cycle.
        if (!scramble) begin
          lfsr_next  = step_val;
          acc_next   = acc_shift;
          count_next = count + 6'd1;
          if (count == LAST) begin
            rand_next  = acc_shift;
            valid_next = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      lfsr    <= SEED_W;
      counter <= '0;
      btn_q   <= 1'b0;
      acc     <= '0;
      count   <= '0;
      rand_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_next;
      lfsr    <= lfsr_next;
      counter <= counter + WIDTH'(1);
      btn_q   <= ScrambleButton;
      acc     <= acc_next;
      count   <= count_next;
      rand_q  <= rand_next;
      valid_q <= valid_next;
    end
  end

  assign Valid    = valid_q;
  assign RandBits = rand_q;

endmodule

// File: tb/tb_lfsr_scrambler.sv
// Self-checking bench for lfsr_scrambler: behavioural reference model plus directed literal checks.
module tb_lfsr_scrambler;

  localparam int          W   = 8;
  localparam int          OW  = 8;
  localparam int          ST  = 8;
  localparam logic [31:0] SD  = 32'd1;
  localparam logic [31:0] WMASK = (32'd1 << W) - 32'd1;
  localparam logic [31:0] OMASK = (32'd1 << OW) - 32'd1;

  logic          clk;
  logic          rst;
  logic          btn;
  logic          req;
  logic          busy;
  logic          valid;
  logic [OW-1:0] rand_bits;

  int total = 0;
  int bad   = 0;

  lfsr_scrambler #(
    .WIDTH(W),
    .OUT_W(OW),
    .STEPS(ST),
    .SEED (SD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ScrambleButton(btn),
    .Req           (req),
    .Busy          (busy),
    .Valid         (valid),
    .RandBits      (rand_bits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: collects output bits in a queue; word = last OW bits.
  logic [31:0] m_lfsr, m_cnt, m_word;
  logic        m_btnq, m_gen, m_valid, started, sc_edge;
  bit          m_bits[$];

  function automatic logic [31:0] m_step(input logic [31:0] s);
    int pos[4];
    logic f;
    case (W)
      8:       pos = '{8, 6, 5, 4};
      16:      pos = '{16, 15, 13, 4};
      24:      pos = '{24, 23, 22, 17};
      default: pos = '{32, 22, 2, 1};
    endcase
    f = 1'b0;
    foreach (pos[i]) f ^= s[pos[i]-1];
    return ((s << 1) | {31'd0, f}) & WMASK;
  endfunction

  function automatic logic [31:0] m_pack();
    logic [31:0] w;
    w = '0;
    foreach (m_bits[i]) w = (w << 1) | {31'd0, m_bits[i]};
    return w & OMASK;
  endfunction

  initial started = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_lfsr  = SD & WMASK;
      m_cnt   = '0;
      m_word  = '0;
      m_btnq  = 1'b0;
      m_gen   = 1'b0;
      m_valid = 1'b0;
      m_bits.delete();
      started = 1'b1;
    end else if (started) begin
      sc_edge = btn & ~m_btnq;
      m_valid = 1'b0;
      if (sc_edge) begin
        m_lfsr = m_lfsr ^ m_cnt;
        if (m_lfsr == 0) m_lfsr = SD & WMASK;
      end
      if (m_gen) begin
        if (!sc_edge) begin
          m_bits.push_back(m_lfsr[W-1]);
          m_lfsr = m_step(m_lfsr);
          if (m_bits.size() == ST) begin
            m_word  = m_pack();
            m_valid = 1'b1;
            m_gen   = 1'b0;
          end
        end
      end else if (req) begin
        m_gen = 1'b1;
        m_bits.delete();
      end
      m_btnq = btn;
      m_cnt  = (m_cnt + 1) & WMASK;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("busy",  {31'd0, busy},  {31'd0, m_gen});
      check("valid", {31'd0, valid}, {31'd0, m_valid});
      check("rand_bits", 32'(rand_bits), m_word);
      check("lfsr", 32'(dut.lfsr), m_lfsr);
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    req = 1'b0;
    btn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_valid(input int lim);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL wait_valid: got no Valid within %0d cycles", lim);
    end
  endtask

  task automatic pulse_req();
    @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_cnt(input logic [31:0] v);
    for (int i = 0; i < 600; i++) begin
      if (m_cnt == v) break;
      @(negedge clk);
    end
    check("wait_cnt", m_cnt, v);
  endtask

  initial begin
    int n;
    bit seen;
    do_reset();

    // One Req pulse: 8 busy cycles then word 0x01, lfsr 0x1C.
    pulse_req();
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (busy) n++;
      if (valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("busy_cycles", n, 8);
    check("first_valid_seen", {31'd0, seen}, 32'd1);
    check("word1", 32'(rand_bits), 32'h01);
    check("lfsr_after1", 32'(dut.lfsr), 32'h1C);

    pulse_req();
    wait_valid(20);
    check("word2", 32'(rand_bits), 32'h1C);

    // Held Req: words every 9 cycles.
    do_reset();
    req = 1'b1;
    wait_valid(20);
    check("held_word1", 32'(rand_bits), 32'h01);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (valid) break;
    end
    req = 1'b0;
    check("valid_interval", n, 9);
    check("held_word2", 32'(rand_bits), 32'h1C);
    repeat (3) @(negedge clk);

    // Scramble with counter=5 on lfsr=0x01.
    do_reset();
    wait_cnt(32'd5);
    btn = 1'b1;
    @(negedge clk);
    check("scramble_lfsr", 32'(dut.lfsr), 32'h04);
    btn = 1'b0;
    pulse_req();
    wait_valid(20);
    check("scramble_word", 32'(rand_bits), 32'h04);

    // Scramble that would fold to zero reloads SEED.
    do_reset();
    wait_cnt(32'd1);
    btn = 1'b1;
    @(negedge clk);
    check("zero_fold_lfsr", 32'(dut.lfsr), 32'h01);
    btn = 1'b0;

    // Reset mid-word.
    do_reset();
    pulse_req();
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_rand", 32'(rand_bits), 32'h00);
    rst = 1'b0;
    pulse_req();
    wait_valid(20);
    check("post_rst_word", 32'(rand_bits), 32'h01);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      req = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) btn = ~btn;
      rst = ($urandom_range(0, 499) == 0);
    end
    rst = 1'b0;
    req = 1'b0;
    repeat (12) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
